// File: rtl/apb_command_requester.sv
// apb_command_requester
//   Single-outstanding APB requester. A valid/ready command is turned into
//   one APB SETUP + ACCESS transaction. Completion produces a one-cycle
//   response pulse carrying read data and error status. A watchdog aborts
//   an ACCESS phase that never sees pready.
//
// Ports
//   clk, rst          clock (also APB pclk), synchronous active-high reset
//   cmd_*             command stream (valid/ready, write, addr, wdata, strb)
//   resp_*            response pulse (valid, rdata, err, timeout)
//   apb_*             APB requester interface
module apb_command_requester #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    resp_timeout,
  output logic                    apb_psel,
  output logic                    apb_penable,
  output logic                    apb_pwrite,
  output logic [ADDR_WIDTH-1:0]   apb_paddr,
  output logic [DATA_WIDTH-1:0]   apb_pwdata,
  output logic [DATA_WIDTH/8-1:0] apb_pstrb,
  input  logic                    apb_pready,
  input  logic [DATA_WIDTH-1:0]   apb_prdata,
  input  logic                    apb_pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  // Width of $clog2(TIMEOUT+1); kept at least 1 so the disabled case elaborates.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (DATA_WIDTH != 32) begin : g_bad_width
      $error("apb_command_requester: DATA_WIDTH must be 32");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rvld_q, rvld_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rerr_q, rerr_d;
  logic                    rto_q, rto_d;
  logic                    wd_expire;

  // Watchdog fires on the last permitted ACCESS cycle (counter == TIMEOUT-1),
  // so ACCESS lasts at most TIMEOUT cycles. pready takes priority below.
  generate
    if (TIMEOUT > 0) begin : g_wd
      assign wd_expire = (cnt_q == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_wd
      assign wd_expire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    cnt_d     = cnt_q;
    rvld_d    = 1'b0;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    rto_d     = rto_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          pstrb_d   = cmd_write ? cmd_strb : '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (apb_pready) begin
          rvld_d    = 1'b1;
          rdata_d   = pwrite_q ? '0 : apb_prdata;
          rerr_d    = apb_pslverr;
          rto_d     = 1'b0;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else if (wd_expire) begin
          rvld_d    = 1'b1;
          rdata_d   = '0;
          rerr_d    = 1'b1;
          rto_d     = 1'b1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      cnt_q     <= '0;
      rvld_q    <= 1'b0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      rto_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      cnt_q     <= cnt_d;
      rvld_q    <= rvld_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
      rto_q     <= rto_d;
    end
  end

  // Ready is a plain IDLE decode, masked while reset is asserted.
  assign cmd_ready    = (state_q == IDLE) && !rst;
  assign resp_valid   = rvld_q;
  assign resp_rdata   = rdata_q;
  assign resp_err     = rerr_q;
  assign resp_timeout = rto_q;
  assign apb_psel     = psel_q;
  assign apb_penable  = penable_q;
  assign apb_pwrite   = pwrite_q;
  assign apb_paddr    = paddr_q;
  assign apb_pwdata   = pwdata_q;
  assign apb_pstrb    = pstrb_q;

endmodule
